uart_frame_packer: RTL
======================

// Module: uart_frame_packer
// PURPOSE
//  Collects 16-bit DSP result samples over a valid/ready stream and assembles fixed-size byte frames.
//  Frame layout: header, sequence byte, samples MSB-first, XOR checksum.
//  Presents each frame as one parallel [DEPTH-1:0][7:0] vector on a valid/ready port.
//  Sits directly upstream of uart_tx: down_valid/down_ready/frame_o connect to up_valid/up_ready/data_i.
//  uart_tx is instantiated with DEPTH = 2*N_SAMPLES+3; frame_o[0] is the first byte on the line.
// PARAMETERS
//  N_SAMPLES  4     samples per frame (1..64); DEPTH = 2*N_SAMPLES+3 (localparam, exported)
//  HEADER     8'hA5 constant value of byte 0
// PORTS
//  clk         in   1              system clock, all logic on posedge
//  arstn       in   1              reset, synchronous, active-low
//  in_valid    in   1              sample valid
//  in_ready    out  1              packer accepts a sample this cycle
//  in_data     in   16             sample
//  flush       in   1              close the current partial frame (pulse)
//  down_valid  out  1              frame_o holds a complete frame
//  down_ready  in   1              downstream (uart_tx) accepts the frame
//  frame_o     out  DEPTH x 8      frame bytes, element 0 sent first
//  seq_o       out  7              sequence number of the next frame to emit
// BEHAVIOUR
//  Reset (arstn=0 at posedge):
//   - state=COLLECT; in_ready=1, down_valid=0, seq_o=0, sample count=0, frame_o=all 0.
//   - Reset mid-frame discards collected samples and any held frame.
//  FSM, 2 states:
//   - COLLECT: in_ready=1, down_valid=0.
//     - Each in_valid&in_ready stores in_data at slot cnt (bytes 2+2cnt = [15:8], 3+2cnt = [7:0]) and increments cnt.
//     - Accepting sample N_SAMPLES-1 -> HOLD next cycle.
//     - flush=1 with cnt>0 (after counting any sample accepted in the same cycle) -> HOLD as a partial frame.
//     - A flush that coincides with the filling sample yields a full frame, partial flag 0.
//     - flush with cnt==0 and no accept: ignored.
//   - HOLD: in_ready=0, down_valid=1, frame_o stable.
//     - flush is ignored.
//     - down_valid&down_ready -> COLLECT next cycle; cnt=0; seq_o+=1 (7-bit, wraps 127->0).
//  Frame contents, registered when entering HOLD:
//   - byte0 = HEADER.
//   - byte1 = {partial, seq_o}.
//   - unfilled sample slots = 8'h00.
//   - byte DEPTH-1 = XOR of bytes 0..DEPTH-2.
//  Latency and throughput:
//   - Latency: down_valid rises 1 cycle after the accepting/flush edge.
//   - Minimum frame turnaround: N_SAMPLES accept cycles + 1 HOLD cycle.
//   - Input is stalled while HOLD waits on uart_tx.
//  Output timing: all outputs are registered or derived from state only; no combinational in->out paths.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic {COLLECT, HOLD} packer_state_t.
//   - localparam UART_HEADER = 8'hA5.
//   - function frame_depth(n) = 2*n+3.
//  Single module; the checksum is a function in uart_pkg (xor_bytes).
//  No sub-module needed.
// TESTING
//  T1 N_SAMPLES=4: push 16'h1234,16'h5678,16'h9ABC,16'hDEF0, down_ready=1 -> one frame
//     A5 00 12 34 56 78 9A BC DE F0 cs(=XOR of the 10 preceding bytes); down_valid 1 cycle after the 4th accept.
//  T2 two samples 16'h0102,16'h0304, then flush -> A5 80 01 02 03 04 00 00 00 00 cs; seq_o 0->1 after handshake.
//  T3 hold down_ready=0 for 50 cycles in HOLD with in_valid=1 -> in_ready=0 and frame_o constant throughout;
//     release -> exactly one handshake, then back to COLLECT.
//  T4 128 consecutive full frames -> byte1 runs 00..7F, then the 129th frame carries 00 (wrap).
//  T5 flush in the same cycle as the 4th sample -> full frame, byte1[7]=0.
//     flush with cnt=0 -> no frame.
//  T6 arstn=0 for 1 cycle after 2 samples and again during HOLD -> next posedge in_ready=1, down_valid=0, seq_o=0;
//     the next frame contains only post-reset samples.
//  End-to-end: packer -> uart_tx (clk_mhz=50, boadrate=9600) -> serial monitor decodes the T1 bytes in order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame packer.
// Frame depth and the XOR checksum are defined here.
package uart_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_t;

  localparam logic [7:0] UART_HEADER = 8'hA5;

  // Largest frame: 64 samples -> 2*64+3 bytes.
  localparam int MAX_DEPTH = 131;

  function automatic int frame_depth(input int n);
    return 2 * n + 3;
  endfunction

  // XOR over every byte of a zero-padded frame image.
  function automatic logic [7:0] xor_bytes(
    input logic [MAX_DEPTH*8-1:0] b
  );
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      acc = acc ^ b[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_frame_packer.sv
// Packs 16-bit samples into header/seq/payload/checksum frames.
// One complete frame is presented in parallel to uart_tx.
module uart_frame_packer
  import uart_pkg::*;
#(
  parameter int         N_SAMPLES = 4,
  parameter logic [7:0] HEADER    = UART_HEADER,
  localparam int        DEPTH     = frame_depth(N_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_data,
  input  logic                  flush,
  output logic                  down_valid,
  input  logic                  down_ready,
  output logic [DEPTH-1:0][7:0] frame_o,
  output logic [6:0]            seq_o
);

  localparam int CW = $clog2(N_SAMPLES + 1);

  packer_state_t                state;
  logic [CW-1:0]                cnt;
  logic [CW-1:0]                cnt_nxt;
  logic [N_SAMPLES-1:0][15:0]   smp;
  logic [N_SAMPLES-1:0][15:0]   smp_nxt;
  logic                         accept;
  logic                         full;
  logic                         go_hold;
  logic [DEPTH-1:0][7:0]        body;
  logic [MAX_DEPTH*8-1:0]       flat;
  logic [7:0]                   csum;

  assign in_ready   = (state == COLLECT);
  assign down_valid = (state == HOLD);
  assign accept     = in_ready & in_valid;
  assign cnt_nxt    = cnt + CW'(accept);
  assign full       = accept && (cnt == CW'(N_SAMPLES - 1));
  assign go_hold    = in_ready &&
                      (full || (flush && (cnt_nxt != '0)));

  // Sample buffer including the sample accepted this cycle.
  always_comb begin
    smp_nxt = smp;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (accept && (cnt == CW'(i))) begin
        smp_nxt[i] = in_data;
      end
    end
  end

  // Frame image without checksum; unfilled slots stay zero.
  always_comb begin
    body    = '0;
    body[0] = HEADER;
    body[1] = {~full, seq_o};
    for (int i = 0; i < N_SAMPLES; i++) begin
      body[2+2*i] = smp_nxt[i][15:8];
      body[3+2*i] = smp_nxt[i][7:0];
    end
    flat = '0;
    flat[DEPTH*8-1:0] = body;
  end

  assign csum = xor_bytes(flat);

  // Collect/hold state machine with frame, count and sequence regs.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state   <= COLLECT;
      cnt     <= '0;
      smp     <= '0;
      seq_o   <= '0;
      frame_o <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          smp <= smp_nxt;
          cnt <= cnt_nxt;
          if (go_hold) begin
            state              <= HOLD;
            frame_o            <= body;
            frame_o[DEPTH-1]   <= csum;
          end
        end
        HOLD: begin
          if (down_ready) begin
            state <= COLLECT;
            cnt   <= '0;
            smp   <= '0;
            seq_o <= seq_o + 7'd1;
          end
        end
      endcase
    end
  end

endmodule
